// File: rtl/sdio_crc_pkg.sv
// Shared CRC definitions for the SDIO CRC engine.
// Polynomials, FSM state type and a width-generic CRC step.
package sdio_crc_pkg;

  localparam int MAX_W = 16;

  localparam logic [6:0]  CRC7_POLY  = 7'h09;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE,
    OUT,
    CHK
  } state_t;

  // One serial CRC step on the low w bits of r.
  function automatic logic [MAX_W-1:0] crc_step(
    input logic [MAX_W-1:0] r,
    input logic             din,
    input logic [MAX_W-1:0] poly,
    input int               w
  );
    logic [MAX_W-1:0] top;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] nx;
    logic             fb;
    top  = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    fb   = din ^ (|(r & top));
    nx   = (r << 1) ^ (fb ? poly : '0);
    return nx & mask;
  endfunction

endpackage

// File: rtl/sdio_crc_lane.sv
// One serial CRC lane: accumulate, shift-out and receive compare.
// Ports: clk, rst, clr, gen, shift, chk, chk_clr, din -> r, dout, err.
module sdio_crc_lane
  import sdio_crc_pkg::*;
#(
  parameter int               CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY  = 7'h09,
  parameter logic [CRC_W-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             gen,
  input  logic             shift,
  input  logic             chk,
  input  logic             chk_clr,
  input  logic             din,
  output logic [CRC_W-1:0] r,
  output logic             dout,
  output logic             err
);

  logic [MAX_W-1:0] nxt_gen;

  assign nxt_gen = crc_step(MAX_W'(r), din,
                            MAX_W'(POLY), CRC_W);
  assign dout    = r[CRC_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= INIT;
    end else if (clr) begin
      r <= INIT;
    end else if (gen) begin
      r <= nxt_gen[CRC_W-1:0];
    end else if (shift) begin
      r <= {r[CRC_W-2:0], 1'b0};
    end
  end

  // Sticky: survives clr so a result can be read after an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (chk_clr) begin
      err <= 1'b0;
    end else if (chk && (din != r[CRC_W-1])) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/sdio_crc_engine.sv
// Multi-lane serial CRC engine (CRC7 CMD / CRC16 DAT) for SDIO.
// Ports: clk, rst, ce, clr, gen_en, out_start, chk_start, din ->
//        dout, crc_reg, busy, done, crc_err.
module sdio_crc_engine
  import sdio_crc_pkg::*;
#(
  parameter int               CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY  = 7'h09,
  parameter logic [CRC_W-1:0] INIT  = '0,
  parameter int               LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   clr,
  input  logic                   gen_en,
  input  logic                   out_start,
  input  logic                   chk_start,
  input  logic [LANES-1:0]       din,
  output logic [LANES-1:0]       dout,
  output logic [LANES*CRC_W-1:0] crc_reg,
  output logic                   busy,
  output logic                   done,
  output logic [LANES-1:0]       crc_err
);

  localparam int CW = (CRC_W > 1) ? $clog2(CRC_W) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CRC_W - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          done_n;
  logic          gen;
  logic          shift;
  logic          chk;
  logic          chk_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    gen     = 1'b0;
    shift   = 1'b0;
    chk     = 1'b0;
    chk_clr = 1'b0;
    if (clr) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (out_start) begin
            state_n = OUT;
            cnt_n   = CNT_TOP;
          end else if (chk_start) begin
            state_n = CHK;
            cnt_n   = CNT_TOP;
            chk_clr = 1'b1;
          end else begin
            gen = gen_en & ce;
          end
        end
        OUT, CHK: begin
          if (ce) begin
            shift = 1'b1;
            chk   = (state == CHK);
            if (cnt == '0) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              cnt_n = cnt - 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sdio_crc_lane #(
      .CRC_W (CRC_W),
      .POLY  (POLY),
      .INIT  (INIT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .gen     (gen),
      .shift   (shift),
      .chk     (chk),
      .chk_clr (chk_clr),
      .din     (din[i]),
      .r       (crc_reg[i*CRC_W +: CRC_W]),
      .dout    (dout[i]),
      .err     (crc_err[i])
    );
  end

endmodule

// File: tb/tb_sdio_crc_engine.sv
// Directed bench for sdio_crc_engine: CRC7 single lane and
// CRC16 four lanes, with hand-computed expected values.
module tb_sdio_crc_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       a_ce = 0, a_clr = 0, a_gen_en = 0;
  logic       a_out_start = 0, a_chk_start = 0;
  logic       a_din = 0;
  logic       a_dout;
  logic [6:0] a_crc_reg;
  logic       a_busy, a_done;
  logic       a_crc_err;

  logic        b_ce = 0, b_clr = 0, b_gen_en = 0;
  logic        b_out_start = 0, b_chk_start = 0;
  logic [3:0]  b_din = 0;
  logic [3:0]  b_dout;
  logic [63:0] b_crc_reg;
  logic        b_busy, b_done;
  logic [3:0]  b_crc_err;

  sdio_crc_engine u7 (
    .clk       (clk),
    .rst       (rst),
    .ce        (a_ce),
    .clr       (a_clr),
    .gen_en    (a_gen_en),
    .out_start (a_out_start),
    .chk_start (a_chk_start),
    .din       (a_din),
    .dout      (a_dout),
    .crc_reg   (a_crc_reg),
    .busy      (a_busy),
    .done      (a_done),
    .crc_err   (a_crc_err)
  );

  sdio_crc_engine #(
    .CRC_W (16),
    .POLY  (16'h1021),
    .INIT  (16'h0000),
    .LANES (4)
  ) u16 (
    .clk       (clk),
    .rst       (rst),
    .ce        (b_ce),
    .clr       (b_clr),
    .gen_en    (b_gen_en),
    .out_start (b_out_start),
    .chk_start (b_chk_start),
    .din       (b_din),
    .dout      (b_dout),
    .crc_reg   (b_crc_reg),
    .busy      (b_busy),
    .done      (b_done),
    .crc_err   (b_crc_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_clear();
    a_clr = 1;
    tick();
    a_clr = 0;
  endtask

  task automatic gen7(input logic [39:0] v);
    a_gen_en = 1;
    a_ce = 1;
    for (int i = 39; i >= 0; i--) begin
      a_din = v[i];
      tick();
    end
    a_gen_en = 0;
    a_din = 0;
  endtask

  task automatic gen16_ones();
    b_clr = 1;
    tick();
    b_clr = 0;
    b_gen_en = 1;
    b_ce = 1;
    b_din = 4'hF;
    repeat (4096) tick();
    b_gen_en = 0;
    b_din = 0;
    checks++;
    if (b_crc_reg !== {4{16'h7FA1}}) begin
      failures++;
      $display("FAIL crc16_gen got=%h exp=%h",
               b_crc_reg, {4{16'h7FA1}});
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    checks++;
    if (a_crc_reg !== 7'h00 || a_dout !== 1'b0) begin
      failures++;
      $display("FAIL reset_reg got=%h/%b exp=00/0",
               a_crc_reg, a_dout);
    end
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 ||
        a_crc_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b%b exp=000",
               a_busy, a_done, a_crc_err);
    end
    checks++;
    if (b_crc_reg !== 64'h0 || b_busy !== 1'b0 ||
        b_crc_err !== 4'h0) begin
      failures++;
      $display("FAIL reset_b got=%h %b %h exp=0 0 0",
               b_crc_reg, b_busy, b_crc_err);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_crc7_gen();
    a_clear();
    gen7(40'h4000000000);
    checks++;
    if (a_crc_reg !== 7'h4A) begin
      failures++;
      $display("FAIL crc7_cmd0 got=%h exp=4a", a_crc_reg);
    end
  endtask

  task automatic test_crc7_out();
    logic [6:0] seq;
    int dn;
    seq = 7'b1001010;
    dn = 0;
    a_ce = 1;
    a_out_start = 1;
    tick();
    a_out_start = 0;
    checks++;
    if (a_busy !== 1'b1) begin
      failures++;
      $display("FAIL out_busy got=%b exp=1", a_busy);
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (a_dout !== seq[6-k]) begin
        failures++;
        $display("FAIL out_dout%0d got=%b exp=%b",
                 k, a_dout, seq[6-k]);
      end
      tick();
      if (a_done === 1'b1) dn++;
    end
    tick();
    if (a_done === 1'b1) dn++;
    tick();
    if (a_done === 1'b1) dn++;
    checks++;
    if (dn !== 1) begin
      failures++;
      $display("FAIL out_done got=%0d pulses exp=1", dn);
    end
    checks++;
    if (a_crc_reg !== 7'h00 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL out_end got=%h/%b exp=00/0",
               a_crc_reg, a_busy);
    end
  endtask

  task automatic test_crc7_cmd17();
    a_clear();
    gen7(40'h5100000000);
    checks++;
    if (a_crc_reg !== 7'h2A) begin
      failures++;
      $display("FAIL crc7_cmd17 got=%h exp=2a", a_crc_reg);
    end
  endtask

  task automatic test_abort();
    a_clear();
    gen7(40'h4000000000);
    a_ce = 1;
    a_out_start = 1;
    tick();
    a_out_start = 0;
    tick();
    tick();
    checks++;
    if (a_crc_reg !== 7'h28) begin
      failures++;
      $display("FAIL abort_mid got=%h exp=28", a_crc_reg);
    end
    a_clr = 1;
    tick();
    a_clr = 0;
    checks++;
    if (a_busy !== 1'b0 || a_crc_reg !== 7'h00 ||
        a_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_clr got=%b/%h/%b exp=0/00/0",
               a_busy, a_crc_reg, a_done);
    end
    tick();
    checks++;
    if (a_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_nodone got=%b exp=0", a_done);
    end
  endtask

  task automatic test_contention();
    a_clear();
    gen7(40'h4000000000);
    a_ce = 1;
    a_chk_start = 1;
    tick();
    a_chk_start = 0;
    a_din = 0;
    repeat (7) tick();
    tick();
    checks++;
    if (a_crc_err !== 1'b1) begin
      failures++;
      $display("FAIL chk7_err got=%b exp=1", a_crc_err);
    end
    a_clear();
    gen7(40'h4000000000);
    a_out_start = 1;
    a_chk_start = 1;
    tick();
    a_out_start = 0;
    a_chk_start = 0;
    checks++;
    if (a_busy !== 1'b1 || a_crc_err !== 1'b1) begin
      failures++;
      $display("FAIL both_start got=%b/%b exp=1/1",
               a_busy, a_crc_err);
    end
    a_gen_en = 1;
    a_din = 1;
    repeat (3) tick();
    checks++;
    if (a_crc_reg !== 7'h50) begin
      failures++;
      $display("FAIL out_gen_ign got=%h exp=50", a_crc_reg);
    end
    repeat (4) tick();
    a_gen_en = 0;
    a_din = 0;
    checks++;
    if (a_crc_reg !== 7'h00) begin
      failures++;
      $display("FAIL out_zero got=%h exp=00", a_crc_reg);
    end
  endtask

  task automatic test_crc16_chk_gate();
    logic [15:0] e;
    logic [63:0] snap;
    int dn;
    e = 16'h7FA1;
    dn = 0;
    gen16_ones();
    b_chk_start = 1;
    tick();
    b_chk_start = 0;
    for (int k = 0; k < 16; k++) begin
      b_din = {4{e[15-k]}};
      if (k == 8) begin
        b_ce = 0;
        snap = b_crc_reg;
        repeat (10) begin
          tick();
          if (b_done === 1'b1) dn++;
        end
        checks++;
        if (b_crc_reg !== snap || b_busy !== 1'b1) begin
          failures++;
          $display("FAIL ce_freeze got=%h/%b exp=%h/1",
                   b_crc_reg, b_busy, snap);
        end
        b_ce = 1;
      end
      tick();
      if (k == 14) begin
        checks++;
        if (b_done !== 1'b0) begin
          failures++;
          $display("FAIL chk_early got=%b exp=0", b_done);
        end
      end
      if (b_done === 1'b1) dn++;
    end
    b_din = 0;
    checks++;
    if (dn !== 1 || b_done !== 1'b1) begin
      failures++;
      $display("FAIL chk_done got=%0d/%b exp=1/1", dn, b_done);
    end
    checks++;
    if (b_crc_err !== 4'b0000 || b_crc_reg !== 64'h0) begin
      failures++;
      $display("FAIL chk_ok got=%b/%h exp=0000/0",
               b_crc_err, b_crc_reg);
    end
    tick();
  endtask

  task automatic test_crc16_chk_err();
    logic [15:0] e;
    e = 16'h7FA1;
    gen16_ones();
    b_chk_start = 1;
    tick();
    b_chk_start = 0;
    for (int k = 0; k < 16; k++) begin
      b_din = {4{e[15-k]}};
      if (15 - k == 5) b_din[2] = ~b_din[2];
      tick();
    end
    b_din = 0;
    tick();
    checks++;
    if (b_crc_err !== 4'b0100) begin
      failures++;
      $display("FAIL chk_lane2 got=%b exp=0100", b_crc_err);
    end
  endtask

  initial begin
    test_reset();
    test_crc7_gen();
    test_crc7_out();
    test_crc7_cmd17();
    test_abort();
    test_contention();
    test_crc16_chk_gate();
    test_crc16_chk_err();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
